// File: rtl/song_sequencer_if.sv
`timescale 1ns/1ps
// song_sequencer_if
//   Control, table-write and tone-output bundle of the song sequencer.
//   master : drives start/song_sel/stop/loop, the table write port
//            (wr_en/wr_song/wr_addr/wr_data) and, when
//            SONG_SEQUENCER_TEMPO_EN is defined, tempo; observes the outputs.
//   slave  : the sequencer; drives note_period/note_on/busy/done/cur_addr.
interface song_sequencer_if #(
  parameter int NUM_SONGS = 4,
  parameter int DEPTH     = 32,
  parameter int NOTE_W    = 4,
  parameter int DUR_W     = 2,
  parameter int PERIOD_W  = 20
);
  localparam int SONG_W  = $clog2(NUM_SONGS);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int ENTRY_W = 1 + NOTE_W + DUR_W;

  logic                start;
  logic [SONG_W-1:0]   song_sel;
  logic                stop;
  logic                loop;
  logic                wr_en;
  logic [SONG_W-1:0]   wr_song;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ENTRY_W-1:0]  wr_data;
`ifdef SONG_SEQUENCER_TEMPO_EN
  logic [2:0]          tempo;
`endif
  logic [PERIOD_W-1:0] note_period;
  logic                note_on;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   cur_addr;

  modport master (
`ifdef SONG_SEQUENCER_TEMPO_EN
    output tempo,
`endif
    output start, song_sel, stop, loop, wr_en, wr_song, wr_addr, wr_data,
    input  note_period, note_on, busy, done, cur_addr
  );

  modport slave (
`ifdef SONG_SEQUENCER_TEMPO_EN
    input  tempo,
`endif
    input  start, song_sel, stop, loop, wr_en, wr_song, wr_addr, wr_data,
    output note_period, note_on, busy, done, cur_addr
  );
endinterface

// File: rtl/song_sequencer.sv
`timescale 1ns/1ps
// song_sequencer
//   Multi-song note sequencer. NUM_SONGS tables of DEPTH entries
//   {valid, note, dur} are written at runtime; a start request plays the
//   selected table with beat timing, a silent gap after each note, rests
//   (note codes >= 8), loop-at-end and stop.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sq         : song_sequencer_if.slave (start/song_sel/stop/loop, table
//                write port, note_period/note_on/busy/done/cur_addr)
// Optional feature: define SONG_SEQUENCER_TEMPO_EN to add sq.tempo[2:0];
//   each beat then lasts (tempo+1)*TICKS_PER_BEAT cycles, tempo being
//   captured when a note is fetched. The gap is not scaled.
// NOTE_W must be at least 4 (codes 0..7 are tones, the rest are rests).
module song_sequencer #(
  parameter int NUM_SONGS      = 4,
  parameter int DEPTH          = 32,
  parameter int NOTE_W         = 4,
  parameter int DUR_W          = 2,
  parameter int TICKS_PER_BEAT = 12500000,
  parameter int GAP_TICKS      = 1000000,
  parameter int PERIOD_W       = 20
) (
  input logic             clk,
  input logic             rst_n,
  song_sequencer_if.slave sq
);
  localparam int SONG_W  = $clog2(NUM_SONGS);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int ENTRY_W = 1 + NOTE_W + DUR_W;
  localparam int TICK_W  = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam int GAP_W   = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

  // Half-period counts at 100 MHz for C4..C5; rests give 0.
  function automatic logic [PERIOD_W-1:0] note_half_period(input logic [NOTE_W-1:0] code);
    logic [PERIOD_W-1:0] p;
    p = '0;
    if (code[NOTE_W-1:3] == '0) begin
      case (code[2:0])
        3'd0:    p = PERIOD_W'(191109);
        3'd1:    p = PERIOD_W'(170264);
        3'd2:    p = PERIOD_W'(151685);
        3'd3:    p = PERIOD_W'(143172);
        3'd4:    p = PERIOD_W'(127551);
        3'd5:    p = PERIOD_W'(113636);
        3'd6:    p = PERIOD_W'(101238);
        default: p = PERIOD_W'(95556);
      endcase
    end
    return p;
  endfunction

  logic [ENTRY_W-1:0]  mem [NUM_SONGS*DEPTH];
  logic [ENTRY_W-1:0]  rd_q;

  state_t              state_q;
  logic [SONG_W-1:0]   song_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DUR_W-1:0]    dur_q;
  logic [DUR_W-1:0]    beat_q;
  logic [TICK_W-1:0]   tick_q;
  logic [GAP_W-1:0]    gap_q;
  logic [PERIOD_W-1:0] note_period_q;
  logic                note_on_q;
  logic                busy_q;
  logic                done_q;

  logic                rd_valid;
  logic [NOTE_W-1:0]   rd_note;
  logic [DUR_W-1:0]    rd_dur;
  logic                start_go;
  logic                pre_last;
  logic                play_end;
  logic                gap_end;
  logic                adv;
  logic [SONG_W-1:0]   rd_song;
  logic [ADDR_W-1:0]   rd_addr;

  assign rd_valid = rd_q[ENTRY_W-1];
  assign rd_note  = rd_q[DUR_W +: NOTE_W];
  assign rd_dur   = rd_q[DUR_W-1:0];

  assign start_go = sq.start && !sq.stop;

`ifdef SONG_SEQUENCER_TEMPO_EN
  logic [2:0] tempo_q;
  logic [2:0] pre_q;
  assign pre_last = (pre_q == tempo_q);
`else
  assign pre_last = 1'b1;
`endif

  assign play_end = pre_last && (tick_q == TICK_LAST) && (beat_q == dur_q);
  assign gap_end  = (gap_q == GAP_LAST);
  // End of the silent tail of an entry: move on to the next entry.
  assign adv = ((state_q == GAP) && gap_end) ||
               ((state_q == PLAY) && play_end && (GAP_TICKS == 0));

  // The read address follows the addr/song the FSM is about to load, so the
  // entry is already in rd_q during the FETCH cycle. Incrementing past
  // DEPTH-1 wraps to entry 0 of the same song, which is the loop restart.
  always_comb begin
    rd_song = song_q;
    rd_addr = addr_q;
    if (start_go) begin
      rd_song = sq.song_sel;
      rd_addr = '0;
    end else if ((state_q == FETCH) && !rd_valid) begin
      rd_addr = '0;
    end else if (adv) begin
      rd_addr = addr_q + 1'b1;
    end
  end

  // Table storage: write-first is not provided, a same-cycle read sees old data.
  always_ff @(posedge clk) begin
    if (sq.wr_en) mem[{sq.wr_song, sq.wr_addr}] <= sq.wr_data;
    rd_q <= mem[{rd_song, rd_addr}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      song_q        <= '0;
      addr_q        <= '0;
      dur_q         <= '0;
      beat_q        <= '0;
      tick_q        <= '0;
      gap_q         <= '0;
      note_period_q <= '0;
      note_on_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef SONG_SEQUENCER_TEMPO_EN
      tempo_q       <= '0;
      pre_q         <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (sq.stop && (state_q != IDLE)) begin
        state_q       <= IDLE;
        addr_q        <= '0;
        busy_q        <= 1'b0;
        note_on_q     <= 1'b0;
        note_period_q <= '0;
        done_q        <= 1'b1;
      end else if (start_go) begin
        state_q       <= FETCH;
        song_q        <= sq.song_sel;
        addr_q        <= '0;
        busy_q        <= 1'b1;
        note_on_q     <= 1'b0;
        note_period_q <= '0;
      end else begin
        case (state_q)
          FETCH: begin
            if (rd_valid) begin
              dur_q         <= rd_dur;
              beat_q        <= '0;
              tick_q        <= '0;
              note_on_q     <= (rd_note[NOTE_W-1:3] == '0);
              note_period_q <= note_half_period(rd_note);
              state_q       <= PLAY;
`ifdef SONG_SEQUENCER_TEMPO_EN
              tempo_q       <= sq.tempo;
              pre_q         <= '0;
`endif
            end else if (sq.loop) begin
              addr_q <= '0;
            end else begin
              state_q <= IDLE;
              addr_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          PLAY: begin
`ifdef SONG_SEQUENCER_TEMPO_EN
            pre_q <= pre_last ? 3'd0 : pre_q + 3'd1;
`endif
            if (pre_last) begin
              if (tick_q == TICK_LAST) begin
                tick_q <= '0;
                beat_q <= beat_q + 1'b1;
              end else begin
                tick_q <= tick_q + 1'b1;
              end
            end
            if (play_end) begin
              note_on_q     <= 1'b0;
              note_period_q <= '0;
              gap_q         <= '0;
              state_q       <= GAP;
            end
          end
          GAP: begin
            gap_q <= gap_q + 1'b1;
          end
          default: ;
        endcase
        // Entry finished; overrides the state chosen above.
        if (adv) begin
          if ((addr_q == ADDR_LAST) && !sq.loop) begin
            state_q <= IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= FETCH;
          end
        end
      end
    end
  end

  assign sq.note_period = note_period_q;
  assign sq.note_on     = note_on_q;
  assign sq.busy        = busy_q;
  assign sq.done        = done_q;
  assign sq.cur_addr    = addr_q;

endmodule
